// File: rtl/fifo_pkg.sv
// Shared widths and default parameters for the parameterised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W    = 128;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AEMPTY_TH = 2;

    // Pointers carry one extra wrap bit above the entry index.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Occupancy must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// FIFO push/pop bus: master drives requests and write data, slave is the FIFO itself.
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);

    logic                      wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic                      rd_en;
    logic [DATA_W-1:0]         rd_data;
    logic                      full;
    logic                      empty;
    logic                      almost_full;
    logic                      almost_empty;
    logic [cnt_w(DEPTH)-1:0]   count;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one address-indexed combinational read port.
module fifo_mem #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with registered flags, overflow/underflow pulses.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is registered read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic               clk,
    input  logic               rst,
    param_sync_fifo_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] AF_LVL = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_LVL = CW'(AEMPTY_TH);

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_push;
    logic              w_pop;
    logic [PW-1:0]     w_wr_ptr_nxt;
    logic [PW-1:0]     w_rd_ptr_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic [DATA_W-1:0] w_mem_rdata;

    // A simultaneous pop frees the slot, so a push at full is still taken.
    assign w_push       = bus.wr_en && (!r_full || bus.rd_en);
    assign w_pop        = bus.rd_en && !r_empty;
    assign w_wr_ptr_nxt = w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;
    assign w_count_nxt  = CW'(w_wr_ptr_nxt - w_rd_ptr_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_full      <= (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                           (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
            r_empty     <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_afull     <= (w_count_nxt >= AF_LVL);
            r_aempty    <= (w_count_nxt <= AE_LVL);
            r_overflow  <= bus.wr_en && r_full && !bus.rd_en;
            r_underflow <= bus.rd_en && r_empty;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Head word is visible combinationally; forced to zero while empty.
    assign bus.rd_data = r_empty ? '0 : w_mem_rdata;
`else
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (w_pop) begin
            r_rd_data <= w_mem_rdata;
        end
    end

    assign bus.rd_data = r_rd_data;
`endif

    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo (DATA_W=128, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2).
module tb_param_sync_fifo;

    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int AF_TH = 14;
    localparam int AE_TH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    param_sync_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    param_sync_fifo #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AF_TH),
        .AEMPTY_TH (AE_TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            m_cnt    = 0;
    logic [DW-1:0] sb_q[$];
    logic          pend     = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_pop();
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_data: popped %0h with scoreboard empty at %0t", bus.rd_data, $time);
        end else begin
            chk("rd_data", bus.rd_data, sb_q.pop_front());
        end
    endtask

    // Monitor: compares read data whenever the FIFO presents a popped word.
    always @(negedge clk) begin
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        if (!rst && bus.rd_en && !bus.empty) check_pop();
`else
        if (pend) check_pop();
        pend = !rst && bus.rd_en && !bus.empty;
`endif
    end

    // Drive one cycle, advance the reference model, then check all flags #1 after the edge.
    task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd);
        logic exp_ovf;
        logic exp_udf;
        logic push;
        logic pop;
        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.rd_en   = rd;
        @(posedge clk);
        exp_ovf = wr && (m_cnt == DEPTH) && !rd;
        exp_udf = rd && (m_cnt == 0);
        push    = wr && ((m_cnt < DEPTH) || rd);
        pop     = rd && (m_cnt > 0);
        if (push) sb_q.push_back(d);
        m_cnt = m_cnt + int'(push) - int'(pop);
        #1;
        chk("count",        DW'(bus.count),        DW'(m_cnt));
        chk("full",         DW'(bus.full),         DW'(m_cnt == DEPTH));
        chk("empty",        DW'(bus.empty),        DW'(m_cnt == 0));
        chk("almost_full",  DW'(bus.almost_full),  DW'(m_cnt >= AF_TH));
        chk("almost_empty", DW'(bus.almost_empty), DW'(m_cnt <= AE_TH));
        chk("overflow",     DW'(bus.overflow),     DW'(exp_ovf));
        chk("underflow",    DW'(bus.underflow),    DW'(exp_udf));
    endtask

    // Reset with requests asserted; they must be ignored.
    task automatic do_reset();
        rst         = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = DW'(128'hDEAD);
        bus.rd_en   = 1'b1;
        @(posedge clk);
        #1;
        m_cnt = 0;
        sb_q.delete();
        chk("rst_count",        DW'(bus.count),        DW'(0));
        chk("rst_full",         DW'(bus.full),         DW'(0));
        chk("rst_empty",        DW'(bus.empty),        DW'(1));
        chk("rst_almost_full",  DW'(bus.almost_full),  DW'(0));
        chk("rst_almost_empty", DW'(bus.almost_empty), DW'(1));
        chk("rst_overflow",     DW'(bus.overflow),     DW'(0));
        chk("rst_underflow",    DW'(bus.underflow),    DW'(0));
        chk("rst_rd_data",      bus.rd_data,           DW'(0));
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        do_reset();

        // Fill 0..15, then one rejected push.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0);
        cycle(1'b1, DW'(99), 1'b0);

        // Drain in order, then one rejected pop.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);

        // Simultaneous push/pop at full: 0xAA comes out last.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(100 + i), 1'b0);
        cycle(1'b1, DW'(128'hAA), 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);

        // Simultaneous push/pop at empty: push only, underflow pulses.
        cycle(1'b1, DW'(128'h55), 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Steady occupancy of 5 across several pointer wraps.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(200 + i), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, DW'(300 + i), 1'b1);

        // Build to 9 entries, then reset mid-operation.
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(400 + i), 1'b0);
        chk("count_before_reset", DW'(bus.count), DW'(9));
        do_reset();

        // Post-reset sanity with a wide data word.
        cycle(1'b1, {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        chk("scoreboard_drained", DW'(sb_q.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
